ram_stream_loader: RTL

- Upstream feeder for port 2 (s2) of the 256 x 32 dual-port on-chip RAM.
- Accepts a byte stream (e.g. UART receive path) through a valid/ready handshake.
- Packs bytes little-endian into 32-bit words and writes them to consecutive RAM addresses, starting from a programmed base.
- The CPU side keeps port 1 and polls busy/done, the byte checksum and the written-word count.

---
 rtl/ram_stream_loader_pkg.sv | 23 ++
 rtl/ram_stream_loader_if.sv | 23 ++
 rtl/ram_stream_loader_packer.sv | 37 +++
 rtl/ram_stream_loader.sv | 111 +++++++++++
 4 files changed

// File: rtl/ram_stream_loader_pkg.sv
// Shared types and constants for the byte-stream to RAM port-2 loader.
package ram_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    FINISH  = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_IDX_W     = 2;

  localparam logic [BYTES_PER_WORD-1:0] LANES_NONE = 4'b0000;
  localparam logic [BYTES_PER_WORD-1:0] LANES_ALL  = 4'b1111;

  function automatic logic [BYTES_PER_WORD-1:0] lane_bit(input logic [LANE_IDX_W-1:0] idx);
    logic [BYTES_PER_WORD-1:0] mask;
    mask = 4'b0001 << idx;
    return mask;
  endfunction

endpackage

// File: rtl/ram_stream_loader_if.sv
// Byte-stream handshake plus RAM port-2 write bus seen by the loader.
interface ram_stream_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] address2;
  logic [3:0]            byteenable2;
  logic                  chipselect2;
  logic                  write2;
  logic [31:0]           writedata2;

  modport master (
    input  in_data, in_valid,
    output in_ready, address2, byteenable2, chipselect2, write2, writedata2
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, address2, byteenable2, chipselect2, write2, writedata2
  );
endinterface

// File: rtl/ram_stream_loader_packer.sv
// Little-endian byte-to-word packer: tracks the lane index, lane enables and word data.
module stream_word_packer
  import ram_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      accept,
  input  logic [7:0]                data,
  output logic [31:0]               word,
  output logic [BYTES_PER_WORD-1:0] lanes,
  output logic                      full
);

  logic [LANE_IDX_W-1:0] idx;

  // clear has priority so an abort drops a byte arriving in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx   <= '0;
      lanes <= LANES_NONE;
      word  <= '0;
    end else if (clear) begin
      idx   <= '0;
      lanes <= LANES_NONE;
      word  <= '0;
    end else if (accept) begin
      word[{idx, 3'b000} +: 8] <= data;
      lanes                    <= lanes | lane_bit(idx);
      idx                      <= idx + LANE_IDX_W'(1);
    end
  end

  // high while the next accepted byte completes the word
  assign full = (idx == LANE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/ram_stream_loader.sv
// Loads a valid/ready byte stream into consecutive words of RAM port 2.
//  state   | meaning
//  IDLE    | waiting for start; status holds last transfer
//  COLLECT | accepting bytes into the packer
//  WRITE   | one-cycle RAM write of the packed word
//  FINISH  | one-cycle done pulse
module ram_stream_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int COUNT_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] byte_count,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [15:0]            checksum,
  output logic [ADDR_WIDTH:0]    words_written,
  ram_stream_loader_if.master    bus
);

  state_t                    state, state_nxt;
  logic [ADDR_WIDTH-1:0]     ptr;
  logic [COUNT_WIDTH-1:0]    remaining;
  logic                      start_take, abort_take, accept, last_byte, in_write;
  logic                      pk_clear, pk_full;
  logic [31:0]               pk_word;
  logic [BYTES_PER_WORD-1:0] pk_lanes;

  assign in_write   = (state == WRITE);
  assign start_take = (state == IDLE) && start;
  assign abort_take = abort && ((state == COLLECT) || (state == WRITE));
  assign accept     = (state == COLLECT) && bus.in_valid;
  assign last_byte  = (remaining == COUNT_WIDTH'(1));
  assign pk_clear   = start_take || in_write || abort_take;

  stream_word_packer u_packer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (pk_clear),
    .accept  (accept),
    .data    (bus.in_data),
    .word    (pk_word),
    .lanes   (pk_lanes),
    .full    (pk_full)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (byte_count != '0) ? COLLECT : FINISH;
      COLLECT: begin
        if (abort)                             state_nxt = IDLE;
        else if (accept && (pk_full || last_byte)) state_nxt = WRITE;
      end
      WRITE: begin
        if (abort)                  state_nxt = IDLE;
        else if (remaining != '0)   state_nxt = COLLECT;
        else                        state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      aborted       <= 1'b0;
      ptr           <= '0;
      remaining     <= '0;
      checksum      <= '0;
      words_written <= '0;
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt != IDLE);
      aborted <= abort_take;
      if (start_take) begin
        ptr           <= base_addr;
        remaining     <= byte_count;
        checksum      <= '0;
        words_written <= '0;
      end else begin
        if (accept) begin
          checksum  <= checksum + 16'(bus.in_data);
          remaining <= remaining - COUNT_WIDTH'(1);
        end
        // a write coinciding with abort still lands, so it is still counted
        if (in_write) begin
          ptr           <= ptr + ADDR_WIDTH'(1);
          words_written <= words_written + (ADDR_WIDTH + 1)'(1);
        end
      end
    end
  end

  assign done            = (state == FINISH);
  assign bus.in_ready    = (state == COLLECT);
  assign bus.chipselect2 = in_write;
  assign bus.write2      = in_write;
  assign bus.byteenable2 = in_write ? pk_lanes : LANES_NONE;
  assign bus.address2    = in_write ? ptr : '0;
  assign bus.writedata2  = in_write ? pk_word : '0;

endmodule
